full_leds_axil_regs: RTL and testbench

//  AXI4-Lite responder behind the full_leds VIP master: 4 x 32-bit read/write registers driving board LEDs.

---
 rtl/full_leds_pkg.sv | 44 ++++
 rtl/full_leds_blink.sv | 43 ++++
 rtl/full_leds_axil_regs.sv | 226 ++++++++++++++++++++++
 tb/tb_full_leds_axil_regs.sv | 553 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/full_leds_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : full_leds_pkg
//  Purpose  : Shared definitions for the full_leds AXI4-Lite register block:
//             register byte offsets, register index enum, response code and
//             the byte-lane write-strobe merge helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package full_leds_pkg;

    localparam logic [3:0] c_OFF_CTRL         = 4'h0;
    localparam logic [3:0] c_OFF_BLINK_MASK   = 4'h4;
    localparam logic [3:0] c_OFF_BLINK_PERIOD = 4'h8;
    localparam logic [3:0] c_OFF_SCRATCH      = 4'hC;

    // Index equals byte offset [3:2]
    typedef enum logic [1:0] {
        REG_CTRL         = 2'd0,
        REG_BLINK_MASK   = 2'd1,
        REG_BLINK_PERIOD = 2'd2,
        REG_SCRATCH      = 2'd3
    } reg_idx_e;

    localparam logic [1:0] c_RESP_OKAY = 2'b00;

    // Replace only the byte lanes whose strobe bit is set
    function automatic logic [31:0] f_strb_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                result[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage : full_leds_pkg
`default_nettype wire

// File: rtl/full_leds_blink.sv
`default_nettype none
// ============================================================================
//  Module   : full_leds_blink
//  Purpose  : Free-running blink phase generator. A 32-bit counter runs from
//             0 up to i_period and wraps, toggling o_phase on each wrap.
//             A zero period parks counter and phase at 0.
//  Ports    : clk      - clock
//             rst      - synchronous active-high reset
//             i_clear  - restart counter and phase (period register written)
//             i_period - wrap value of the counter
//             o_phase  - current blink phase
//  Revision : 1.0 - initial release
// ============================================================================
module full_leds_blink (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic [31:0] i_period,
    output logic        o_phase
);

    logic [31:0] r_count;
    logic        r_phase;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= 32'd0;
            r_phase <= 1'b0;
        end else if (i_period == 32'd0) begin
            r_count <= 32'd0;
            r_phase <= 1'b0;
        end else if (r_count == i_period) begin
            r_count <= 32'd0;
            r_phase <= ~r_phase;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_phase = r_phase;

endmodule : full_leds_blink
`default_nettype wire

// File: rtl/full_leds_axil_regs.sv
`default_nettype none
// ============================================================================
//  Module   : full_leds_axil_regs
//  Purpose  : AXI4-Lite responder with four 32-bit R/W registers
//             (CTRL, BLINK_MASK, BLINK_PERIOD, SCRATCH) driving board LEDs.
//             Build option FULL_LEDS_BLINK_EN adds a blink engine that XORs
//             BLINK_MASK onto CTRL with a phase toggling every
//             BLINK_PERIOD+1 cycles; otherwise LEDS follow CTRL directly.
//  Ports    : ACLK / ARESET      - clock, synchronous active-high reset
//             S_AXI_AW*          - write address channel (AWPROT ignored)
//             S_AXI_W*           - write data channel with byte strobes
//             S_AXI_B*           - write response (always OKAY)
//             S_AXI_AR*          - read address channel (ARPROT ignored)
//             S_AXI_R*           - read data / response (always OKAY)
//             LEDS               - registered LED drive
//  Revision : 1.0 - initial release
// ============================================================================
module full_leds_axil_regs
    import full_leds_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int LED_WIDTH          = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [LED_WIDTH-1:0]            LEDS
);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] r_regs [4];

    // ------------------------------------------------------------------
    // Write path: AW and W are captured independently into holding
    // registers. A write commits on the edge where both an address and a
    // data beat are available, whether held or arriving that cycle.
    // ------------------------------------------------------------------
    logic        r_aw_held;
    reg_idx_e    r_aw_idx;
    logic        r_w_held;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;

    logic        w_aw_fire;
    logic        w_w_fire;
    logic        w_have_aw;
    logic        w_have_w;
    logic        w_commit;
    reg_idx_e    w_wr_idx;
    logic [31:0] w_wr_data;
    logic [3:0]  w_wr_strb;
    logic        w_aw_held_nx;
    logic        w_w_held_nx;
    logic        w_bvalid_nx;

    assign w_aw_fire    = S_AXI_AWVALID && r_awready;
    assign w_w_fire     = S_AXI_WVALID  && r_wready;
    assign w_have_aw    = r_aw_held || w_aw_fire;
    assign w_have_w     = r_w_held  || w_w_fire;
    assign w_commit     = w_have_aw && w_have_w;
    assign w_wr_idx     = r_aw_held ? r_aw_idx : reg_idx_e'(S_AXI_AWADDR[3:2]);
    assign w_wr_data    = r_w_held  ? r_wdata  : S_AXI_WDATA[31:0];
    assign w_wr_strb    = r_w_held  ? r_wstrb  : S_AXI_WSTRB[3:0];
    assign w_aw_held_nx = w_have_aw && !w_commit;
    assign w_w_held_nx  = w_have_w  && !w_commit;
    assign w_bvalid_nx  = w_commit || (r_bvalid && !S_AXI_BREADY);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aw_held <= 1'b0;
            r_aw_idx  <= REG_CTRL;
            r_w_held  <= 1'b0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            r_aw_held <= w_aw_held_nx;
            r_w_held  <= w_w_held_nx;
            r_bvalid  <= w_bvalid_nx;
            // Readies are registered from next-state so they drop the
            // cycle after a beat is held or a response is pending.
            r_awready <= !w_aw_held_nx && !w_bvalid_nx;
            r_wready  <= !w_w_held_nx  && !w_bvalid_nx;
            if (w_aw_fire) begin
                r_aw_idx <= reg_idx_e'(S_AXI_AWADDR[3:2]);
            end
            if (w_w_fire) begin
                r_wdata <= S_AXI_WDATA[31:0];
                r_wstrb <= S_AXI_WSTRB[3:0];
            end
            if (w_commit) begin
                r_regs[w_wr_idx] <= f_strb_merge(r_regs[w_wr_idx], w_wr_data, w_wr_strb);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path FSM
    // ------------------------------------------------------------------
    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_DATA = 1'b1;

    logic [0:0]  r_rd_state;
    logic [0:0]  w_rd_state_nx;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        w_ar_fire;

    assign w_ar_fire = S_AXI_ARVALID && r_arready;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rd_state <= c_R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nx;
        end
    end

    always_comb begin
        w_rd_state_nx = r_rd_state;
        case (r_rd_state)
            c_R_IDLE: if (w_ar_fire)    w_rd_state_nx = c_R_DATA;
            c_R_DATA: if (S_AXI_RREADY) w_rd_state_nx = c_R_IDLE;
            default:                    w_rd_state_nx = c_R_IDLE;
        endcase
    end

    // RDATA samples the register array before any same-edge write lands,
    // so a colliding read returns the pre-write value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_arready <= (w_rd_state_nx == c_R_IDLE);
            r_rvalid  <= (w_rd_state_nx == c_R_DATA);
            if (w_ar_fire) begin
                r_rdata <= r_regs[reg_idx_e'(S_AXI_ARADDR[3:2])];
            end
        end
    end

    // ------------------------------------------------------------------
    // LED drive
    // ------------------------------------------------------------------
    logic [LED_WIDTH-1:0] w_leds_nx;
    logic [LED_WIDTH-1:0] r_leds;

`ifdef FULL_LEDS_BLINK_EN
    logic w_phase;
    logic w_blink_clear;

    assign w_blink_clear = w_commit && (w_wr_idx == REG_BLINK_PERIOD);

    full_leds_blink u_blink (
        .clk      (ACLK),
        .rst      (ARESET),
        .i_clear  (w_blink_clear),
        .i_period (r_regs[REG_BLINK_PERIOD]),
        .o_phase  (w_phase)
    );

    assign w_leds_nx = r_regs[REG_CTRL][LED_WIDTH-1:0]
                     ^ (r_regs[REG_BLINK_MASK][LED_WIDTH-1:0] & {LED_WIDTH{w_phase}});
`else
    assign w_leds_nx = r_regs[REG_CTRL][LED_WIDTH-1:0];
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_leds <= '0;
        end else begin
            r_leds <= w_leds_nx;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = c_RESP_OKAY;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = C_S_AXI_DATA_WIDTH'(r_rdata);
    assign S_AXI_RRESP   = c_RESP_OKAY;
    assign LEDS          = r_leds;

    // Protection bits and sub-word address bits carry no meaning here
    logic w_unused;
    assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule : full_leds_axil_regs
`default_nettype wire

// File: tb/tb_full_leds_axil_regs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_full_leds_axil_regs
//  Purpose  : Self-checking bench for full_leds_axil_regs. A plain array of
//             four words models the register file; LED expectations are
//             derived from it. Blink scenarios run when FULL_LEDS_BLINK_EN
//             is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_full_leds_axil_regs;

    localparam int c_AW = 8;
    localparam int c_LW = 8;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [c_AW-1:0] S_AXI_AWADDR;
    logic [2:0]      S_AXI_AWPROT;
    logic            S_AXI_AWVALID;
    logic            S_AXI_AWREADY;
    logic [31:0]     S_AXI_WDATA;
    logic [3:0]      S_AXI_WSTRB;
    logic            S_AXI_WVALID;
    logic            S_AXI_WREADY;
    logic [1:0]      S_AXI_BRESP;
    logic            S_AXI_BVALID;
    logic            S_AXI_BREADY;
    logic [c_AW-1:0] S_AXI_ARADDR;
    logic [2:0]      S_AXI_ARPROT;
    logic            S_AXI_ARVALID;
    logic            S_AXI_ARREADY;
    logic [31:0]     S_AXI_RDATA;
    logic [1:0]      S_AXI_RRESP;
    logic            S_AXI_RVALID;
    logic            S_AXI_RREADY;
    logic [c_LW-1:0] LEDS;

    always #5 ACLK = ~ACLK;

    full_leds_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (c_AW),
        .LED_WIDTH          (c_LW)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .LEDS          (LEDS)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_regs [4];

    // ---------------- reference model helpers ----------------
    function automatic int reg_of(input logic [c_AW-1:0] addr);
        return (int'(addr) / 4) % 4;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] s);
        logic [31:0] mask;
        mask = 32'd0;
        for (int i = 0; i < 4; i++) if (s[i]) mask = mask | (32'hFF << (8 * i));
        return (o & ~mask) | (n & mask);
    endfunction

    function automatic bit leds_match(input logic [c_LW-1:0] v);
        logic [31:0] c, m;
        c = model_regs[0];
        m = model_regs[1];
`ifdef FULL_LEDS_BLINK_EN
        return (v == c[c_LW-1:0]) || (v == (c[c_LW-1:0] ^ m[c_LW-1:0]));
`else
        return v == c[c_LW-1:0];
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) model_regs[i] = 32'd0;
    endfunction

    // ---------------- bus drivers ----------------
    task automatic drive_idle();
        S_AXI_AWADDR = '0; S_AXI_AWPROT = 3'd0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'd0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = 3'd0; S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [c_AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int b_delay,
                            output logic [1:0] bresp, output bit ok);
        bit aw_done, w_done, aw_fire, w_fire;
        int n;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        aw_done = 0; w_done = 0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
            w_fire  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_fire) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
            if (w_fire)  begin w_done  = 1; S_AXI_WVALID  = 1'b0; end
            n++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        if (aw_done && w_done)
            model_regs[reg_of(addr)] = model_merge(model_regs[reg_of(addr)], data, strb);
        for (int i = 0; i < b_delay; i++) tick();
        S_AXI_BREADY = 1'b1;
        n = 0;
        while (!S_AXI_BVALID && n < 50) begin tick(); n++; end
        ok    = aw_done && w_done && S_AXI_BVALID;
        bresp = S_AXI_BRESP;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [c_AW-1:0] addr, input int r_delay,
                           output logic [31:0] data, output logic [1:0] rresp, output bit ok);
        bit ar_done, ar_fire;
        int n;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        ar_done = 0; n = 0;
        while (!ar_done && n < 50) begin
            ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
            tick();
            if (ar_fire) begin ar_done = 1; S_AXI_ARVALID = 1'b0; end
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < r_delay; i++) tick();
        S_AXI_RREADY = 1'b1;
        n = 0;
        while (!S_AXI_RVALID && n < 50) begin tick(); n++; end
        ok    = ar_done && S_AXI_RVALID;
        data  = S_AXI_RDATA;
        rresp = S_AXI_RRESP;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; bit ok;
        drive_idle();
        ARESET = 1'b1;
        model_reset();
        repeat (3) tick();
        n_checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0
            || S_AXI_RDATA !== 32'd0 || LEDS !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_outputs: got aw/w/ar/b/r=%b%b%b%b%b rdata=%h leds=%h, required all 0",
                     S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
                     S_AXI_RDATA, LEDS);
        end
        ARESET = 1'b0;
        tick();
        n_checks++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            n_errors++;
            $display("FAIL readies_after_reset: got %b%b%b, required 111",
                     S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(c_AW'(4 * i), 0, d, r, ok);
            n_checks++;
            if (!ok || d !== 32'd0) begin
                n_errors++;
                $display("FAIL reset_reg%0d: ok=%0d got %h, required 00000000", i, ok, d);
            end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic [1:0] r; bit ok;
        for (int i = 0; i < 4; i++) begin
            do_write(c_AW'(4 * i), 32'(i + 1), 4'hF, 0, r, ok);
            n_checks++;
            if (!ok || r !== 2'b00) begin
                n_errors++;
                $display("FAIL write_bresp%0d: ok=%0d got %b, required 00", i, ok, r);
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_read(c_AW'(4 * i), 0, d, r, ok);
            n_checks++;
            if (!ok || d !== 32'(i + 1) || r !== 2'b00) begin
                n_errors++;
                $display("FAIL readback%0d: ok=%0d got %h/%b, required %h/00", i, ok, d, r, i + 1);
            end
        end
        n_checks++;
        if (!leds_match(LEDS)) begin
            n_errors++;
            $display("FAIL leds_ctrl: got %h, required %h (CTRL low byte)", LEDS, model_regs[0][7:0]);
        end
    endtask

    // mode 0: AW first, W 3 cycles later; mode 1: W first; mode 2: same cycle
    task automatic test_aw_w_order();
        logic [31:0] d, exp_d; logic [1:0] r; bit ok;
        for (int mode = 0; mode < 3; mode++) begin
            exp_d = $urandom;
            S_AXI_AWADDR = c_AW'(8'h0C | (($urandom % 16) << 4));
            S_AXI_WDATA  = exp_d;
            S_AXI_WSTRB  = 4'hF;
            S_AXI_AWVALID = (mode != 1);
            S_AXI_WVALID  = (mode != 0);
            tick();
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
            if (mode == 2) begin
                n_checks++;
                if (S_AXI_BVALID !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bvalid_same_cycle: got %b, required 1", S_AXI_BVALID);
                end
            end else begin
                n_checks++;
                if (S_AXI_BVALID !== 1'b0 || (mode == 0 ? S_AXI_AWREADY : S_AXI_WREADY) !== 1'b0) begin
                    n_errors++;
                    $display("FAIL held_mode%0d: got bvalid=%b ready=%b, required 0/0", mode,
                             S_AXI_BVALID, (mode == 0 ? S_AXI_AWREADY : S_AXI_WREADY));
                end
                tick(); tick();
                S_AXI_AWVALID = (mode == 1);
                S_AXI_WVALID  = (mode == 0);
                tick();
                S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
                n_checks++;
                if (S_AXI_BVALID !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bvalid_cycle4_mode%0d: got %b, required 1", mode, S_AXI_BVALID);
                end
            end
            model_regs[3] = exp_d;
            S_AXI_BREADY = 1'b1;
            tick();
            S_AXI_BREADY = 1'b0;
            n_checks++;
            if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011) begin
                n_errors++;
                $display("FAIL after_b_mode%0d: got bvalid/awready/wready=%b%b%b, required 011",
                         mode, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
            end
            do_read(8'h0C, 0, d, r, ok);
            n_checks++;
            if (!ok || d !== exp_d) begin
                n_errors++;
                $display("FAIL order_data_mode%0d: ok=%0d got %h, required %h", mode, ok, d, exp_d);
            end
        end
    endtask

    task automatic test_bready_stall();
        logic [31:0] d1, d2; int bad;
        d1 = $urandom; d2 = $urandom;
        S_AXI_AWADDR = 8'h08; S_AXI_WDATA = d1; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        model_regs[2] = d1;
        S_AXI_WVALID = 1'b0;
        S_AXI_AWADDR = 8'h0C;  // second write address offered during the stall
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b100) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL bready_stall: %0d cycles with bvalid/awready/wready != 100", bad);
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        n_checks++;
        if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_release: got bvalid=%b awready=%b, required 0/1", S_AXI_BVALID, S_AXI_AWREADY);
        end
        tick();  // stalled AW accepted here
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = d2; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        model_regs[3] = d2;
        n_checks++;
        if (S_AXI_BVALID !== 1'b1) begin
            n_errors++;
            $display("FAIL stalled_aw_commit: got bvalid=%b, required 1", S_AXI_BVALID);
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic test_wstrb();
        logic [31:0] d; logic [1:0] r; bit ok;
        do_write(8'h0C, 32'hAABBCCDD, 4'hF, 1, r, ok);
        do_write(8'h0C, 32'h11111111, 4'b0010, 0, r, ok);
        do_read(8'h0C, 0, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'hAABB11DD || d !== model_regs[3]) begin
            n_errors++;
            $display("FAIL wstrb_merge: ok=%0d got %h, required AABB11DD", ok, d);
        end
        do_write(8'h0C, 32'h55555555, 4'b0000, 2, r, ok);
        n_checks++;
        if (!ok || r !== 2'b00) begin
            n_errors++;
            $display("FAIL wstrb0_bresp: ok=%0d got %b, required 00", ok, r);
        end
        do_read(8'h0C, 0, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'hAABB11DD) begin
            n_errors++;
            $display("FAIL wstrb0_noop: ok=%0d got %h, required AABB11DD", ok, d);
        end
    endtask

    task automatic test_rready_stall();
        logic [31:0] exp_d; logic [1:0] r; bit ok; int bad, n;
        exp_d = $urandom;
        do_write(8'h04, exp_d, 4'hF, 0, r, ok);
        S_AXI_ARADDR = 8'h14; S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 20) begin tick(); n++; end
        tick();
        S_AXI_ARVALID = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (S_AXI_RVALID !== 1'b1 || S_AXI_ARREADY !== 1'b0 || S_AXI_RDATA !== exp_d) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL rready_stall_alias: %0d bad cycles, last rdata=%h required %h", bad, S_AXI_RDATA, exp_d);
        end
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        n_checks++;
        if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
            n_errors++;
            $display("FAIL r_release: got rvalid=%b arready=%b, required 0/1", S_AXI_RVALID, S_AXI_ARREADY);
        end
    endtask

    task automatic test_read_write_collide();
        logic [31:0] old_d, new_d, d; logic [1:0] r; bit ok;
        old_d = model_regs[3];
        new_d = ~old_d;
        S_AXI_AWADDR = 8'h0C; S_AXI_WDATA = new_d; S_AXI_WSTRB = 4'hF;
        S_AXI_ARADDR = 8'h0C;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        model_regs[3] = new_d;
        n_checks++;
        if (S_AXI_RVALID !== 1'b1 || S_AXI_BVALID !== 1'b1 || S_AXI_RDATA !== old_d) begin
            n_errors++;
            $display("FAIL collide_pre_write: rvalid=%b bvalid=%b rdata=%h, required 1/1/%h",
                     S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA, old_d);
        end
        S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
        do_read(8'h0C, 0, d, r, ok);
        n_checks++;
        if (!ok || d !== new_d) begin
            n_errors++;
            $display("FAIL collide_post_write: ok=%0d got %h, required %h", ok, d, new_d);
        end
    endtask

    task automatic test_random();
        logic [31:0] d, wd; logic [1:0] r; logic [c_AW-1:0] a; logic [3:0] s; bit ok;
        for (int i = 0; i < 40; i++) begin
            a  = c_AW'($urandom);
            wd = $urandom;
            s  = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, wd, s, $urandom_range(0, 3), r, ok);
                n_checks++;
                if (!ok || r !== 2'b00 || !leds_match(LEDS)) begin
                    n_errors++;
                    $display("FAIL rand_write%0d: ok=%0d bresp=%b leds=%h ctrl=%h", i, ok, r, LEDS, model_regs[0]);
                end
            end else begin
                do_read(a, $urandom_range(0, 3), d, r, ok);
                n_checks++;
                if (!ok || r !== 2'b00 || d !== model_regs[reg_of(a)]) begin
                    n_errors++;
                    $display("FAIL rand_read%0d: addr=%h ok=%0d got %h/%b, required %h/00",
                             i, a, ok, d, r, model_regs[reg_of(a)]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, wd; logic [1:0] r; bit ok; int bad;
        do_write(8'h00, 32'h0000_005A, 4'hF, 0, r, ok);
        S_AXI_AWADDR = 8'h00; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_ARADDR = 8'h00; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        n_checks++;
        if (S_AXI_RVALID !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_read_pending: got rvalid=%b, required 1", S_AXI_RVALID);
        end
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        model_reset();
        n_checks++;
        if (S_AXI_RVALID !== 1'b0 || S_AXI_BVALID !== 1'b0 || LEDS !== 8'h00) begin
            n_errors++;
            $display("FAIL mid_reset_clear: rvalid=%b bvalid=%b leds=%h, required 0/0/00",
                     S_AXI_RVALID, S_AXI_BVALID, LEDS);
        end
        // Lone W after reset: the dropped AW must not pair with it
        wd = $urandom;
        tick();
        S_AXI_WDATA = wd; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (S_AXI_BVALID !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL mid_reset_no_b: %0d cycles with bvalid=1, required 0", bad);
        end
        S_AXI_AWADDR = 8'h0C; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        model_regs[3] = wd;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        do_read(8'h00, 0, d, r, ok);
        n_checks++;
        if (!ok || d !== 32'd0) begin
            n_errors++;
            $display("FAIL mid_reset_ctrl: ok=%0d got %h, required 00000000", ok, d);
        end
        do_read(8'h0C, 0, d, r, ok);
        n_checks++;
        if (!ok || d !== wd) begin
            n_errors++;
            $display("FAIL held_w_commit: ok=%0d got %h, required %h", ok, d, wd);
        end
    endtask

`ifdef FULL_LEDS_BLINK_EN
    task automatic test_blink();
        logic [1:0] r; bit ok;
        logic [7:0] samp [24];
        int last_t, n_tr, bad_val, bad_gap;
        do_write(8'h00, 32'h0, 4'hF, 0, r, ok);
        do_write(8'h04, 32'hFF, 4'hF, 0, r, ok);
        do_write(8'h08, 32'd3, 4'hF, 0, r, ok);
        for (int i = 0; i < 24; i++) begin samp[i] = LEDS; tick(); end
        bad_val = 0; bad_gap = 0; n_tr = 0; last_t = -1;
        for (int i = 0; i < 24; i++) begin
            if (samp[i] != 8'h00 && samp[i] != 8'hFF) bad_val++;
            if (i > 0 && samp[i] != samp[i-1]) begin
                if (last_t >= 0 && (i - last_t) != 4) bad_gap++;
                last_t = i;
                n_tr++;
            end
        end
        n_checks++;
        if (bad_val != 0 || bad_gap != 0 || n_tr < 4) begin
            n_errors++;
            $display("FAIL blink_period3: bad_values=%0d bad_gaps=%0d transitions=%0d, required 0/0/>=4",
                     bad_val, bad_gap, n_tr);
        end
        do_write(8'h08, 32'd0, 4'hF, 0, r, ok);
        bad_val = 0;
        for (int i = 0; i < 8; i++) begin
            if (LEDS !== 8'h00) bad_val++;
            tick();
        end
        n_checks++;
        if (bad_val != 0) begin
            n_errors++;
            $display("FAIL blink_period0: %0d cycles with leds != 00", bad_val);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_aw_w_order();
        test_bready_stall();
        test_wstrb();
        test_rready_stall();
        test_read_write_collide();
        test_random();
        test_reset_mid();
`ifdef FULL_LEDS_BLINK_EN
        test_blink();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_full_leds_axil_regs
`default_nettype wire
